// File: rtl/irq_collector_pkg.sv
// Shared constants and helpers for the interrupt collector.
// Stands in for the IR_NUM / GET_WIDTH definitions used elsewhere in the CPU.
package irq_collector_pkg;

   localparam int IR_NUM = 30;

   typedef enum logic {
      ST_PRIME,
      ST_RUN
   } state_e;

   // Bits needed to hold the value 0..value inclusive.
   function automatic int get_width(input int value);
      return (value < 2) ? 1 : $clog2(value + 1);
   endfunction

endpackage

// File: rtl/irq_collector_line.sv
// One interrupt line: synchroniser, polarity fix, optional glitch filter
// (IRQ_FILTER_EN), edge history and the ir_map output flop.
module irq_line #(
   parameter logic EDGE = 1'b0,
   parameter logic POL  = 1'b0
`ifdef IRQ_FILTER_EN
   ,
   parameter int FILTER_CYCLES = 4
`endif
) (
   input  logic clk,
   input  logic rst_n,
   input  logic dev_irq_i,
   input  logic lvl_en_i,
   input  logic edge_en_i,
   output logic irq_level_o,
   output logic ir_map_o
);

   logic [1:0] sync_q;
   logic       pol_s;
   logic       level;
   logic       hist_q;
   logic       ir_map_q, ir_map_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[0], dev_irq_i};
   end

   assign pol_s = sync_q[1] ^ POL;

`ifdef IRQ_FILTER_EN
   localparam int CW = irq_collector_pkg::get_width(FILTER_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic          flt_q;

   // Counter tracks consecutive cycles the input disagrees with the filtered state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         flt_q <= 1'b0;
      end else if (pol_s == flt_q) begin
         cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
         cnt_q <= '0;
         flt_q <= pol_s;
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   assign level = flt_q;
`else
   assign level = pol_s;
`endif

   assign irq_level_o = level;

   always_comb begin
      ir_map_d = 1'b0;
      if (EDGE) ir_map_d = edge_en_i & level & ~hist_q;
      else      ir_map_d = lvl_en_i & level;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_q   <= 1'b0;
         ir_map_q <= 1'b0;
      end else begin
         hist_q   <= level;
         ir_map_q <= ir_map_d;
      end
   end

   assign ir_map_o = ir_map_q;

endmodule

// File: rtl/irq_collector.sv
// Normalises 30 asynchronous device interrupt lines into CP0 ir_map bits.
// Define IRQ_FILTER_EN to build in the per-line glitch filter.
module irq_collector
   import irq_collector_pkg::*;
#(
   parameter logic [IR_NUM:1] EDGE_MASK     = '0,
   parameter logic [IR_NUM:1] POL_MASK      = '0,
   parameter int              FILTER_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [IR_NUM:1]   dev_irq,
   output logic [IR_NUM:1]   ir_map,
   output logic [IR_NUM:1]   irq_level
);

   if (FILTER_CYCLES < 1 || FILTER_CYCLES > 255) begin : g_bad_filter
      $error("irq_collector: FILTER_CYCLES must be 1..255");
   end

   state_e     state_q;
   logic [1:0] prime_cnt_q;
   logic       lvl_en_q;
   logic       edge_en_q;

   // PRIME covers the release cycle plus two more while the synchronisers fill.
   // Level outputs may load on the PRIME->RUN edge; edge detection starts one
   // cycle later so the history already holds the post-reset level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_PRIME;
         prime_cnt_q <= 2'd0;
         lvl_en_q    <= 1'b0;
         edge_en_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_PRIME: begin
               prime_cnt_q <= prime_cnt_q + 2'd1;
               if (prime_cnt_q == 2'd1) lvl_en_q <= 1'b1;
               if (prime_cnt_q == 2'd2) begin
                  state_q   <= ST_RUN;
                  edge_en_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   for (genvar i = 1; i <= IR_NUM; i++) begin : g_line
      irq_line #(
         .EDGE          (EDGE_MASK[i]),
         .POL           (POL_MASK[i])
`ifdef IRQ_FILTER_EN
         ,
         .FILTER_CYCLES (FILTER_CYCLES)
`endif
      ) u_line (
         .clk         (clk),
         .rst_n       (rst_n),
         .dev_irq_i   (dev_irq[i]),
         .lvl_en_i    (lvl_en_q),
         .edge_en_i   (edge_en_q),
         .irq_level_o (irq_level[i]),
         .ir_map_o    (ir_map[i])
      );
   end

endmodule

// File: tb/tb_irq_collector.sv
// Self-checking bench for irq_collector: directed vectors, startup/edge corner
// sequences and a randomized run against a cycle-indexed reference model.
module tb_irq_collector;

   localparam logic [30:1] EDGE = 30'h0000_084D;  // lines 1,3,4,7,12
   localparam logic [30:1] POL  = 30'h2008_0000;  // lines 20,30
   localparam int FC = 4;
`ifdef IRQ_FILTER_EN
   localparam int LAT = 3 + FC;
   localparam logic [30:1] RST_LVL = '0;
`else
   localparam int LAT = 3;
   localparam logic [30:1] RST_LVL = POL;
`endif
   localparam int NR = 400;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [30:1] dev_irq;
   logic [30:1] ir_map;
   logic [30:1] irq_level;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [30:1] dev;
      logic [30:1] map;
      logic [30:1] lvl;
   } vec_t;
   vec_t vt [5];

   logic [30:1] s1 [0:NR-1];
   logic [30:1] s2 [0:NR-1];
   logic [30:1] raw [0:NR-1];
   logic [30:1] lv [0:NR-1];

   irq_collector #(
      .EDGE_MASK     (EDGE),
      .POL_MASK      (POL),
      .FILTER_CYCLES (FC)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .dev_irq   (dev_irq),
      .ir_map    (ir_map),
      .irq_level (irq_level)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset(input logic [30:1] d);
      rst_n   = 1'b0;
      dev_irq = d;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      int          pulses;
      logic [30:1] d;
      logic [30:1] exp_map;
      logic        all_diff;

      vt[0] = '{30'h0000_0000, 30'h2008_0000, 30'h2008_0000};
      vt[1] = '{30'h3FFF_FFFF, 30'h1FF7_F7B2, 30'h1FF7_FFFF};
      vt[2] = '{30'h2008_0000, 30'h0000_0000, 30'h0000_0000};
      vt[3] = '{30'h0000_0010, 30'h2008_0010, 30'h2008_0010};
      vt[4] = '{30'h1555_5555, 30'h355D_5510, 30'h355D_5555};

      rst_n   = 1'b0;
      dev_irq = '0;
      tick();
      tick();
      chk("reset_map", 32'(ir_map), 32'h0);
      chk("reset_level", 32'(irq_level), 32'(RST_LVL));

`ifndef IRQ_FILTER_EN
      // Edge line 7 and level line 8 already active at reset release.
      do_reset(30'h0000_00C0);
      pulses = 0;
      for (int k = 1; k <= 50; k++) begin
         tick();
         if (ir_map[7]) pulses++;
         if (k == 2) chk("startup_l8_prime", 32'(ir_map[8]), 32'd0);
         if (k == 3) chk("startup_l8_first_run", 32'(ir_map[8]), 32'd1);
      end
      chk("startup_l7_no_pulse", pulses, 0);
`endif

      do_reset('0);
      repeat (LAT + 6) tick();
      for (int i = 0; i < 5; i++) begin
         dev_irq = vt[i].dev;
         repeat (LAT + 3) tick();
         chk($sformatf("vec%0d_map", i), 32'(ir_map), 32'(vt[i].map));
         chk($sformatf("vec%0d_level", i), 32'(irq_level), 32'(vt[i].lvl));
      end
      dev_irq = '0;
      repeat (LAT + 3) tick();

      // Level line 5 held high for 10 sampled cycles.
      dev_irq[5] = 1'b1;
      for (int k = 1; k <= LAT + 12; k++) begin
         tick();
         chk($sformatf("lvl5_k%0d", k), 32'(ir_map[5]), 32'((k >= LAT) && (k <= LAT + 9)));
         if (k == 10) dev_irq[5] = 1'b0;
      end

      // Edge line 1: long high, 5-cycle low, rise again.
      dev_irq[1] = 1'b1;
      pulses = 0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (ir_map[1]) pulses++;
         if (k == LAT) chk("edge1_first", 32'(ir_map[1]), 32'd1);
         if (k == LAT + 25) chk("edge1_second", 32'(ir_map[1]), 32'd1);
         if (k == 20) dev_irq[1] = 1'b0;
         if (k == 25) dev_irq[1] = 1'b1;
      end
      chk("edge1_pulse_count", pulses, 2);
      dev_irq[1] = 1'b0;
      repeat (LAT + 3) tick();

      // Active-low line 30.
      dev_irq[30] = 1'b1;
      repeat (LAT + 2) tick();
      chk("pol30_inactive", 32'(ir_map[30]), 32'd0);
      dev_irq[30] = 1'b0;
      for (int k = 1; k <= LAT; k++) begin
         tick();
         if (k == LAT - 1) chk("pol30_before", 32'(ir_map[30]), 32'd0);
         if (k == LAT) chk("pol30_assert", 32'(ir_map[30]), 32'd1);
      end

      // Simultaneous edges on lines 3 and 4, then async reset mid-pulse.
      dev_irq[30] = 1'b1;
      repeat (LAT + 3) tick();
      dev_irq[4:3] = 2'b11;
      for (int k = 1; k <= LAT; k++) tick();
      chk("edge34_same_cycle", 32'(ir_map[4:3]), 32'h3);
      rst_n = 1'b0;
      #1;
      chk("async_reset_clear", 32'(ir_map), 32'h0);
      tick();

`ifdef IRQ_FILTER_EN
      do_reset('0);
      repeat (12) tick();
      dev_irq[2] = 1'b1;
      repeat (3) tick();
      dev_irq[2] = 1'b0;
      pulses = 0;
      for (int k = 1; k <= 15; k++) begin
         tick();
         if (ir_map[2]) pulses++;
      end
      chk("filter_glitch", pulses, 0);
      dev_irq[2] = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (k == 6) chk("filter_before", 32'(ir_map[2]), 32'd0);
         if (k == 7) chk("filter_assert", 32'(ir_map[2]), 32'd1);
         if (k == 6) dev_irq[2] = 1'b0;
      end
`endif

      // Randomized run from reset against the reference model.
      rst_n   = 1'b0;
      dev_irq = 30'($urandom);
      tick();
      rst_n  = 1'b1;
      s1[0]  = '0;
      s2[0]  = '0;
      raw[0] = POL;
`ifdef IRQ_FILTER_EN
      lv[0] = '0;
`else
      lv[0] = POL;
`endif
      for (int e = 1; e < NR; e++) begin
         d = dev_irq;
         tick();
         s1[e]  = d;
         s2[e]  = s1[e-1];
         raw[e] = s2[e] ^ POL;
`ifdef IRQ_FILTER_EN
         for (int i = 1; i <= 30; i++) begin
            lv[e][i] = lv[e-1][i];
            if (e >= FC) begin
               all_diff = 1'b1;
               for (int k = 1; k <= FC; k++)
                  if (raw[e-k][i] == lv[e-1][i]) all_diff = 1'b0;
               if (all_diff) lv[e][i] = ~lv[e-1][i];
            end
         end
`else
         lv[e] = raw[e];
`endif
         if (e < 3)      exp_map = '0;
         else if (e < 4) exp_map = lv[e-1] & ~EDGE;
         else            exp_map = (lv[e-1] & ~EDGE) | (lv[e-1] & ~lv[e-2] & EDGE);
         chk($sformatf("rnd_level_e%0d", e), 32'(irq_level), 32'(lv[e]));
         chk($sformatf("rnd_map_e%0d", e), 32'(ir_map), 32'(exp_map));
         dev_irq = dev_irq ^ 30'($urandom & $urandom & $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
